// File: rtl/ask_pkg.sv
// Shared types and default sizing for the ASK word scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ask_pkg;

  localparam int WORD_W_DEF     = 10;
  localparam int DEPTH_DEF      = 4;
  localparam int GAP_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    XMIT  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/ask_word_fifo.sv
// Word FIFO between the load synchronizer and the frame scheduler.
// Latency: push visible in count_o the next cycle; rdata_o shows the head combinationally.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module ask_word_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally at DEPTH (power of two); count only moves on unbalanced push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ask_word_sched.sv
// Queues button-loaded words and hands them one frame at a time to an ASK modulator.
// Latency: 3 clk load->fifo_count, +1 clk to tx_valid; GAP_CYCLES+1 clk from tx_done to next offer.
// Backpressure: word held on tx_valid until tx_ready; loads into a full FIFO are dropped (sticky overflow).
// Optional ASK_SCHED_REPEAT_EN: with an empty FIFO, re-offer the last sent word as a beacon.
module ask_word_sched
  import ask_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [WORD_W-1:0]        word_in,
  input  logic                     tx_ready,
  input  logic                     tx_done,
  output logic                     tx_valid,
  output logic [WORD_W-1:0]        tx_word,
  output logic                     new_word,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_t      state_q;
  logic [GW-1:0]     gap_q;
  logic              sync1_q, sync2_q, sync3_q;
  logic              tx_valid_q, new_word_q, overflow_q;
  logic [WORD_W-1:0] tx_word_q;
  logic              load_edge, handoff, pop;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic              beacon_ok, beacon_pop_blk;
  logic [WORD_W-1:0] beacon_word;

  assign load_edge = sync2_q & ~sync3_q;
  assign handoff   = (state_q == OFFER) & tx_ready;
  assign pop       = handoff & ~beacon_pop_blk;

  // Two flops bring the button into clk; the third gives the previous value for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= load;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  ask_word_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (load_edge),
    .wdata_i (word_in),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sticky drop flag: only a load that the FIFO cannot absorb this cycle counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else if (load_edge && fifo_full && !pop) overflow_q <= 1'b1;
  end

`ifdef ASK_SCHED_REPEAT_EN
  logic [WORD_W-1:0] last_q;
  logic              sent_q;
  logic              beacon_q;

  // Track the last handed-off word and whether the pending offer is a replay (no pop).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= '0;
      sent_q   <= 1'b0;
      beacon_q <= 1'b0;
    end else begin
      if (handoff) begin
        last_q <= tx_word_q;
        sent_q <= 1'b1;
      end
      if (state_q == IDLE) beacon_q <= fifo_empty & sent_q;
    end
  end

  assign beacon_ok      = sent_q;
  assign beacon_word    = last_q;
  assign beacon_pop_blk = beacon_q;
`else
  assign beacon_ok      = 1'b0;
  assign beacon_word    = '0;
  assign beacon_pop_blk = 1'b0;
`endif

  // Frame FSM: offer, wait for modulator to finish, then enforce the inter-frame gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_word_q  <= '0;
      new_word_q <= 1'b0;
    end else begin
      new_word_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            tx_word_q  <= fifo_head;
            tx_valid_q <= 1'b1;
            state_q    <= OFFER;
          end else if (beacon_ok) begin
            tx_word_q  <= beacon_word;
            tx_valid_q <= 1'b1;
            state_q    <= OFFER;
          end
        end
        OFFER: begin
          if (tx_ready) begin
            new_word_q <= 1'b1;
            tx_valid_q <= 1'b0;
            state_q    <= XMIT;
          end
        end
        XMIT: begin
          if (tx_done) begin
            gap_q   <= GW'(GAP_CYCLES - 1);
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_word  = tx_word_q;
  assign new_word = new_word_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/ask_word_sched.md
ASK_WORD_SCHED -- requirements
Module: ask_word_sched

Interface
REQ-001 Parameter WORD_W, default 10, width of the data word sent per ASK frame.
REQ-002 Parameter DEPTH, default 4, word FIFO depth; power of two, at least 2.
REQ-003 Parameter GAP_CYCLES, default 16, idle clk cycles forced between consecutive frames; at least 1.
REQ-004 clk  input  1  single clock (PLL output); all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  active-high load request, asynchronous to clk (button, already inverted).
REQ-007 word_in  input  WORD_W  word to enqueue (switch inputs), sampled on the detected load edge.
REQ-008 tx_ready  input  1  modulator idle and able to accept a word.
REQ-009 tx_done  input  1  one-cycle pulse, modulator finished serializing the current word.
REQ-010 tx_valid  output  1  word offered to modulator.
REQ-011 tx_word  output  WORD_W  word offered; stable while tx_valid=1.
REQ-012 new_word  output  1  one-cycle pulse on each accepted handoff.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  words queued.
REQ-014 overflow  output  1  sticky; a load arrived while the FIFO was full.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 load SHALL pass a 2-flop synchronizer; enqueue occurs one cycle after a synchronized 0->1 edge, so latency is 3 clk from load rising to fifo_count increment.
REQ-017 Enqueue when full SHALL drop word_in, keep FIFO contents, and set overflow.
REQ-018 FSM states SHALL be IDLE, OFFER, XMIT, GAP.
REQ-019 IDLE->OFFER when fifo_count>0; tx_word loads the FIFO head the same cycle; tx_valid=1 in OFFER.
REQ-020 Handoff SHALL occur on a cycle with tx_valid && tx_ready: pop FIFO, pulse new_word, go to XMIT, drop tx_valid next cycle.
REQ-021 XMIT->GAP on tx_done; the counter loads GAP_CYCLES-1.
REQ-022 GAP SHALL count down to 0, then go to IDLE; IDLE to the next OFFER takes exactly one further cycle.
REQ-023 Simultaneous enqueue and pop SHALL leave fifo_count unchanged and lose no word, including when full.
REQ-024 tx_done outside XMIT SHALL be ignored.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL saturate at DEPTH and floor at 0.

Reset
REQ-026 On rst_n=0: state IDLE, FIFO empty, tx_valid=0, tx_word=0, new_word=0, fifo_count=0, overflow=0, busy=0, synchronizer flops 0.
REQ-027 Reset mid-frame SHALL abort immediately, discarding queued words; the first post-reset frame waits for a fresh load edge.
REQ-028 overflow SHALL clear only by reset.

Configuration
REQ-029 Macro ASK_SCHED_REPEAT_EN, when defined: in IDLE with FIFO empty, after at least one word has been sent since reset, the last sent word SHALL be re-offered (beacon mode) without popping, and new_word still pulses.
REQ-030 Without ASK_SCHED_REPEAT_EN, the block SHALL stay in IDLE with an empty FIFO and hold no last-word register.

Structure
REQ-031 Package ask_pkg SHALL hold the state enum (sched_state_t) and the default WORD_W, DEPTH and GAP_CYCLES constants.
REQ-032 FIFO SHALL be sub-module ask_word_fifo (push, pop, full, empty, count); the synchronizer, edge detect and FSM are in ask_word_sched.

Verification
REQ-033 Reset, load pulse with word_in=10'h2A5, tx_ready=1 -> fifo_count=1 three cycles after load; next cycle OFFER with tx_word=10'h2A5; new_word pulses once; fifo_count returns to 0.
REQ-034 Five loads (10'h001 to 10'h005) while tx_ready=0 -> fifo_count=4, overflow=1; release -> words 001, 002, 003, 004 sent in order; 005 is never sent.
REQ-035 Two queued words, tx_done pulsed 10 cycles after the first handoff -> second tx_valid rises exactly GAP_CYCLES+1 cycles after tx_done.
REQ-036 FIFO full and load edge on the same cycle as a handoff pop -> fifo_count stays 4, overflow stays 0, the new word is sent last.
REQ-037 rst_n low during XMIT with 2 queued words -> all outputs at their reset values in the same cycle; no tx_valid until a new load.
REQ-038 With ASK_SCHED_REPEAT_EN, one load of 10'h3C3 -> 10'h3C3 re-offered after every GAP and new_word pulses each frame; without the macro, exactly one frame.
